// File: rtl/snn_pkg.sv
// Shared image-loader constants: 28x28 one-bit image delivered as 98 bytes.
// No latency or backpressure; definitions only.
package snn_pkg;
    localparam int IMG_ROWS   = 28;
    localparam int IMG_COLS   = 28;
    localparam int DATA_W     = 8;
    localparam int NUM_BYTES  = 98;
    localparam int NUM_BITS   = DATA_W * NUM_BYTES;
    localparam int ADDR_W     = $clog2(NUM_BITS);
    // Wide enough to hold the terminal count NUM_BYTES, not just the last index.
    localparam int CNT_W      = $clog2(NUM_BYTES + 1);

    typedef enum logic {
        LOADING = 1'b0,
        FULL    = 1'b1
    } load_state_e;
endpackage

// File: rtl/load_input_file_if.sv
// Byte-load and bit-read bundle between the image source/consumer and the loader.
// No latency of its own; trigger is a one-cycle strobe with no backpressure.
interface load_input_file_if;
    import snn_pkg::*;

    logic              trigger;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              q;
    logic              ready;

    modport master (output trigger, data, addr, input  q, ready);
    modport slave  (input  trigger, data, addr, output q, ready);
endinterface

// File: rtl/load_input_file_input_bit_mem.sv
// 784x1 image memory: byte-aligned write port, registered 1-bit read port.
// Read latency 1 cycle (old data on same-cycle write); no backpressure.
module input_bit_mem
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [CNT_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_q_o
);
    logic [NUM_BITS-1:0] mem_q;
    logic                rd_q;
    logic [ADDR_W-1:0]   wr_base;

    assign wr_base = ADDR_W'(wr_idx_i) * ADDR_W'(DATA_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            rd_q  <= 1'b0;
        end else begin
            if (we_i) begin
                mem_q[wr_base +: DATA_W] <= wr_dat_i;
            end
            // Addresses past the image read as zero rather than aliasing.
            if (rd_addr_i < ADDR_W'(NUM_BITS)) begin
                rd_q <= mem_q[rd_addr_i];
            end else begin
                rd_q <= 1'b0;
            end
        end
    end

    assign rd_q_o = rd_q;
endmodule

// File: rtl/load_input_file.sv
// Loads one 98-byte binary image into bit memory and raises ready when complete.
// q has 1-cycle read latency; triggers arriving after ready are dropped.
module load_input_file
    import snn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    load_input_file_if.slave  bus
);
    load_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wr_en;

    assign wr_en = bus.trigger && (state_q == LOADING);
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOADING;
            cnt_q   <= '0;
        end else if (wr_en) begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(NUM_BYTES)) begin
                state_q <= FULL;
            end
        end
    end

    assign bus.ready = (state_q == FULL);

    input_bit_mem u_mem (
        .clk       (clk),
        .rst       (rst),
        .we_i      (wr_en),
        .wr_idx_i  (cnt_q),
        .wr_dat_i  (bus.data),
        .rd_addr_i (bus.addr),
        .rd_q_o    (bus.q)
    );
endmodule

// File: tb/tb_load_input_file.sv
// Scoreboard bench for load_input_file: reference image model, expected reads queued.
module tb_load_input_file;
    import snn_pkg::*;

    logic clk;
    logic rst;
    load_input_file_if bus ();

    load_input_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [NUM_BITS-1:0] mdl_img;
    int                  mdl_cnt;
    bit                  mdl_rdy;
    bit                  exp_q[$];

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_img = '0;
        mdl_cnt = 0;
        mdl_rdy = 1'b0;
    endtask

    task automatic send_byte(input logic [DATA_W-1:0] d);
        bus.trigger = 1'b1;
        bus.data    = d;
        tick();
        bus.trigger = 1'b0;
        if (!mdl_rdy) begin
            mdl_img[mdl_cnt*DATA_W +: DATA_W] = d;
            mdl_cnt++;
            if (mdl_cnt == NUM_BYTES) mdl_rdy = 1'b1;
        end
    endtask

    task automatic read_chk(input int a, input string tag);
        bit e;
        bus.addr = ADDR_W'(a);
        exp_q.push_back((a < NUM_BITS) ? mdl_img[a] : 1'b0);
        tick();
        e = exp_q.pop_front();
        chk(tag, bus.q, e);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < NUM_BITS; a++) read_chk(a, tag);
    endtask

    initial begin
        rst         = 1'b0;
        bus.trigger = 1'b0;
        bus.data    = '0;
        bus.addr    = '0;
        mdl_img     = '0;
        mdl_cnt     = 0;
        mdl_rdy     = 1'b0;

        // All-ones image, slow trigger cadence.
        do_reset();
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_q", bus.q, 1'b0);
        for (int k = 0; k < NUM_BYTES; k++) begin
            send_byte(8'hFF);
            chk("ready_slow", bus.ready, (k == NUM_BYTES - 1));
            repeat (50) tick();
        end
        sweep("q_ones");

        // Mixed pattern with explicit bit expectations.
        do_reset();
        send_byte(8'h01);
        send_byte(8'h80);
        for (int k = 0; k < 96; k++) send_byte(8'hA5);
        chk("ready_pat", bus.ready, 1'b1);
        for (int a = 0; a < 24; a++) read_chk(a, "q_pat");
        read_chk(800, "q_oob");
        begin
            logic [23:0] want;
            want = 24'b1010_0101_1000_0000_0000_0001;
            for (int a = 0; a < 24; a++) begin
                bus.addr = ADDR_W'(a);
                tick();
                chk("q_pat_const", bus.q, want[a]);
            end
        end

        // Back-to-back triggers with incrementing data.
        do_reset();
        for (int k = 0; k < NUM_BYTES; k++) begin
            send_byte(DATA_W'(k + 3));
            chk("ready_b2b", bus.ready, (k == NUM_BYTES - 1));
        end
        sweep("q_b2b");

        // Trigger while full is ignored.
        send_byte(8'h00);
        chk("ready_full", bus.ready, 1'b1);
        for (int a = 0; a < 8; a++) read_chk(a, "q_full_keep");

        // Reset mid-load, then a fresh full load.
        do_reset();
        for (int k = 0; k < 40; k++) send_byte(8'h5A);
        chk("ready_mid", bus.ready, 1'b0);
        do_reset();
        chk("ready_after_rst", bus.ready, 1'b0);
        sweep("q_cleared");
        for (int k = 0; k < NUM_BYTES; k++) begin
            send_byte(DATA_W'(255 - k));
            chk("ready_fresh", bus.ready, (k == NUM_BYTES - 1));
        end
        sweep("q_fresh");

        // Reset has priority over a coincident trigger.
        rst         = 1'b1;
        bus.trigger = 1'b1;
        bus.data    = 8'hFF;
        tick();
        rst         = 1'b0;
        bus.trigger = 1'b0;
        mdl_img = '0;
        mdl_cnt = 0;
        mdl_rdy = 1'b0;
        chk("ready_rst_trig", bus.ready, 1'b0);
        send_byte(8'h3C);
        for (int a = 0; a < 16; a++) read_chk(a, "q_rst_trig");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
